// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, column strobes, key map and row priority helper.
// Key map: row0 = 1 2 3 +, row1 = 4 5 6 -, row2 = 7 8 9 =, row3 = C 0.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } kp_state_e;

  // Index 0 drives column 0 low.
  localparam logic [3:0][3:0] COL_STROBE = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  // Raw codes are {row_idx, col_idx}.
  localparam logic [3:0] KEY_1   = 4'b0000;
  localparam logic [3:0] KEY_2   = 4'b0001;
  localparam logic [3:0] KEY_3   = 4'b0010;
  localparam logic [3:0] KEY_ADD = 4'b0011;
  localparam logic [3:0] KEY_4   = 4'b0100;
  localparam logic [3:0] KEY_5   = 4'b0101;
  localparam logic [3:0] KEY_6   = 4'b0110;
  localparam logic [3:0] KEY_SUB = 4'b0111;
  localparam logic [3:0] KEY_7   = 4'b1000;
  localparam logic [3:0] KEY_8   = 4'b1001;
  localparam logic [3:0] KEY_9   = 4'b1010;
  localparam logic [3:0] KEY_EQ  = 4'b1011;
  localparam logic [3:0] KEY_CLR = 4'b1100;
  localparam logic [3:0] KEY_0   = 4'b1101;

  // Lowest-index low row; row0 wins ties.
  function automatic logic [1:0] low_row(
    input logic [3:0] rs
  );
    logic [1:0] idx;
    idx = 2'd3;
    if (!rs[2]) idx = 2'd2;
    if (!rs[1]) idx = 2'd1;
    if (!rs[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer for the asynchronous keypad rows.
// Resets to all-ones so an idle (pulled-up) keypad is seen during reset.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // Two register stages to settle metastability.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 column-strobed keypad scanner with debounce.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 13,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DS = CW'(DEBOUNCE_SCANS);

  logic [3:0]               w_rs;
  logic                     w_tick;
  logic [SCAN_DIV_BITS-1:0] r_div;
  kp_state_e                r_state;
  kp_state_e                w_state;
  logic [1:0]               r_ci;
  logic [1:0]               w_ci;
  logic [1:0]               r_ri;
  logic [1:0]               w_ri;
  logic [CW-1:0]            r_cnt;
  logic [CW-1:0]            w_cnt;
  logic [CW-1:0]            r_rel;
  logic [CW-1:0]            w_rel;
  logic [3:0]               r_code;
  logic [3:0]               w_code;
  logic                     r_valid;
  logic                     w_valid;
  logic                     r_held;
  logic                     w_held;
  logic                     w_rpt_hit;

  keypad_sync #(
    .W(4)
  ) u_sync (
    .i_clk(clk),
    .i_rst(rst),
    .i_d  (row),
    .o_q  (w_rs)
  );

  // Free-running scan divider; a tick is its wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_div <= '0;
    else     r_div <= r_div + SCAN_DIV_BITS'(1);
  end

  assign w_tick = &r_div;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_AT   = RW'(REPEAT_DELAY);
  // Reloading to DELAY-RATE spaces later repeats by RATE ticks;
  // this assumes REPEAT_RATE <= REPEAT_DELAY.
  localparam logic [RW-1:0] RPT_LOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

  logic [RW-1:0] r_rpt;
  logic [RW-1:0] w_rpt;

  // Repeat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rpt <= '0;
    else     r_rpt <= w_rpt;
  end

  // Count held ticks; zero outside PRESSED and on quiet ticks.
  always_comb begin
    w_rpt     = r_rpt;
    w_rpt_hit = 1'b0;
    if (r_state != PRESSED) begin
      w_rpt = '0;
    end else if (w_tick) begin
      if (w_rs == 4'hF) begin
        w_rpt = '0;
      end else if (r_rpt + RW'(1) == RPT_AT) begin
        w_rpt_hit = 1'b1;
        w_rpt     = RPT_LOAD;
      end else begin
        w_rpt = r_rpt + RW'(1);
      end
    end
  end
`else
  logic w_unused_rpt;
  assign w_unused_rpt = (REPEAT_DELAY != 0) ^ (REPEAT_RATE != 0);
  assign w_rpt_hit    = 1'b0;
`endif

  // FSM and datapath state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SCAN;
      r_ci    <= '0;
      r_ri    <= '0;
      r_cnt   <= '0;
      r_rel   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ci    <= w_ci;
      r_ri    <= w_ri;
      r_cnt   <= w_cnt;
      r_rel   <= w_rel;
      r_code  <= w_code;
      r_valid <= w_valid;
      r_held  <= w_held;
    end
  end

  // Next state: scan, debounce a press, then debounce its release.
  always_comb begin
    w_state = r_state;
    w_ci    = r_ci;
    w_ri    = r_ri;
    w_cnt   = r_cnt;
    w_rel   = r_rel;
    w_code  = r_code;
    w_valid = 1'b0;
    w_held  = r_held;
    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          if (w_rs != 4'hF) begin
            w_ri  = low_row(w_rs);
            w_cnt = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              w_code  = {w_ri, r_ci};
              w_valid = 1'b1;
              w_held  = 1'b1;
              w_rel   = '0;
              w_state = PRESSED;
            end else begin
              w_state = DEBOUNCE;
            end
          end else begin
            w_ci = r_ci + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!w_rs[r_ri]) begin
            w_cnt = r_cnt + CW'(1);
            if (w_cnt == DS) begin
              w_code  = {r_ri, r_ci};
              w_valid = 1'b1;
              w_held  = 1'b1;
              w_rel   = '0;
              w_state = PRESSED;
            end
          end else begin
            w_state = SCAN;
            w_ci    = r_ci + 2'd1;
          end
        end
        PRESSED: begin
          if (w_rs == 4'hF) begin
            w_rel = r_rel + CW'(1);
            if (w_rel == DS) begin
              w_rel   = '0;
              w_held  = 1'b0;
              w_state = SCAN;
              w_ci    = r_ci + 2'd1;
            end
          end else begin
            w_rel = '0;
          end
          if (w_rpt_hit) w_valid = 1'b1;
        end
        default: w_state = SCAN;
      endcase
    end
  end

  assign col       = COL_STROBE[r_ci];
  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model, directed and random presses,
// cycle-by-cycle comparison against a behavioural reference.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int DIVB = 2;
  localparam int DS   = 3;
  localparam int RD   = 6;
  localparam int RR   = 2;
  localparam int TK   = 1 << DIVB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [15:0] keys = '0;

  int checks  = 0;
  int errors  = 0;
  int n_pulse = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV_BITS (DIVB),
    .DEBOUNCE_SCANS(DS),
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  // Physical matrix: a pressed key pulls its row low when its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  int         m_div, m_mode, m_ci, m_ri, m_n, m_rel, m_rpt;
  logic [3:0] m_s1, m_s2, m_code;
  bit         m_valid, m_held;

  task automatic m_reset();
    m_div = 0; m_mode = 0; m_ci = 0; m_ri = 0;
    m_n = 0; m_rel = 0; m_rpt = 0;
    m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0;
    m_valid = 0; m_held = 0;
  endtask

  task automatic m_press();
    m_code  = 4'(m_ri * 4 + m_ci);
    m_valid = 1;
    m_held  = 1;
    m_mode  = 2;
    m_rel   = 0;
    m_rpt   = 0;
  endtask

  task automatic m_step();
    logic [3:0] rs;
    bit         tick;
    rs   = m_s2;
    tick = (m_div % TK) == TK - 1;
    m_div++;
    m_valid = 0;
    if (tick) begin
      if (m_mode == 0) begin
        if (rs != 4'hF) begin
          m_ri = 0;
          while (rs[m_ri]) m_ri++;
          m_n = 1;
          if (m_n >= DS) m_press();
          else m_mode = 1;
        end else begin
          m_ci = (m_ci + 1) % 4;
        end
      end else if (m_mode == 1) begin
        if (rs[m_ri] == 1'b0) begin
          m_n++;
          if (m_n >= DS) m_press();
        end else begin
          m_mode = 0;
          m_ci   = (m_ci + 1) % 4;
        end
      end else begin
        if (rs == 4'hF) begin
          m_rel++;
          m_rpt = 0;
          if (m_rel >= DS) begin
            m_held = 0;
            m_mode = 0;
            m_ci   = (m_ci + 1) % 4;
          end
        end else begin
          m_rel = 0;
          m_rpt++;
`ifdef KEYPAD_REPEAT_EN
          if (m_rpt >= RD && (m_rpt - RD) % RR == 0) m_valid = 1;
`endif
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = row;
  endtask

  // Step the model on each rising edge, compare on each falling edge.
  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!rst) m_step();
      @(negedge clk);
      if (rst) m_reset();
      if (key_valid) n_pulse++;
      check("col",   int'(col), int'(4'hF ^ (4'h1 << m_ci)));
      check("valid", int'(key_valid), int'(m_valid));
      check("code",  int'(key_code), int'(m_code));
      check("held",  int'(key_held), int'(m_held));
    end
  end

  task automatic wait_col(input logic [3:0] v, input string nm);
    int k = 0;
    while (col == v && k < 40) begin @(negedge clk); k++; end
    while (col != v && k < 40) begin @(negedge clk); k++; end
    check(nm, int'(col), int'(v));
  endtask

  task automatic wait_pulse(input string nm);
    int k = 0;
    while (!key_valid && k < 80) begin @(negedge clk); k++; end
    check(nm, int'(key_valid), 1);
  endtask

  task automatic wait_release(input string nm);
    int k = 0;
    while (key_held && k < 60) begin @(negedge clk); k++; end
    check(nm, int'(key_held), 0);
  endtask

  logic [3:0] seq_exp [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    int         p0, idx, last, nrep;
    int         offs [$];
    logic [3:0] prev;
    logic [15:0] m;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col",   int'(col), 4'b1110);
    check("rst_valid", int'(key_valid), 0);
    check("rst_code",  int'(key_code), 0);
    check("rst_held",  int'(key_held), 0);
    @(negedge clk); #2 rst = 1'b0;

    // Idle scan: rotation order and four-clock spacing.
    prev = col; idx = 0; last = 0;
    for (int n = 0; n < 24 && idx < 4; n++) begin
      @(negedge clk);
      if (col != prev) begin
        check("scan_seq", int'(col), int'(seq_exp[idx]));
        if (idx > 0) check("scan_gap", n - last, TK);
        last = n; idx++; prev = col;
      end
    end
    check("scan_steps", idx, 4);
    check("idle_pulses", n_pulse, 0);

    // Row1 on col2 held, then released.
    wait_col(4'b1110, "sync_c0");
    p0 = n_pulse;
    keys = 16'h1 << 6;
    wait_pulse("press_seen");
    check("press_code", int'(key_code), 4'b0110);
    check("press_held", int'(key_held), 1);
    offs.delete();
    for (int w = 1; w <= 50; w++) begin
      @(negedge clk);
      if (key_valid) offs.push_back(w);
    end
    check("frozen_col", int'(col), 4'b1011);
`ifdef KEYPAD_REPEAT_EN
    nrep = offs.size();
    check("rpt_count", nrep, 4);
    if (nrep == 4) begin
      check("rpt_1", offs[0], 24);
      check("rpt_2", offs[1], 32);
      check("rpt_3", offs[2], 40);
      check("rpt_4", offs[3], 48);
    end
`else
    nrep = offs.size();
    check("rpt_none", nrep, 0);
`endif
    keys = '0;
    wait_release("release");
    check("resume_col", int'(col), 4'b0111);
`ifndef KEYPAD_REPEAT_EN
    check("one_pulse", n_pulse - p0, 1);
`endif

    // Bounce: row0 low for two ticks on col0.
    wait_col(4'b1110, "sync_b");
    p0 = n_pulse;
    keys = 16'h0001;
    repeat (8) @(negedge clk);
    keys = '0;
    repeat (4) @(negedge clk);
    check("bounce_col", int'(col), 4'b1101);
    check("bounce_none", n_pulse - p0, 0);
    check("bounce_held", int'(key_held), 0);

    // Rows 0 and 3 on col0: row0 wins.
    keys = 16'h1001;
    wait_pulse("prio_seen");
    check("prio_code", int'(key_code), 4'b0000);
    keys = '0;
    wait_release("prio_rel");

    // Reset in the middle of debouncing row2/col1.
    wait_col(4'b1110, "sync_r");
    p0 = n_pulse;
    keys = 16'h1 << 9;
    wait_col(4'b1101, "reach_c1");
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_col",   int'(col), 4'b1110);
    check("arst_valid", int'(key_valid), 0);
    check("arst_code",  int'(key_code), 0);
    check("arst_held",  int'(key_held), 0);
    keys = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    check("arst_none", n_pulse - p0, 0);

    // Random presses, multi-key presses and bounces.
    for (int it = 0; it < 40; it++) begin
      m = 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) m = m | (16'h1 << $urandom_range(0, 15));
      keys = m;
      if ($urandom_range(0, 2) == 0) begin
        for (int b = 0; b < 4; b++) begin
          repeat ($urandom_range(1, 6)) @(negedge clk);
          keys = (keys == 0) ? m : 16'h0;
        end
      end
      repeat ($urandom_range(2, 120)) @(negedge clk);
      keys = '0;
      repeat ($urandom_range(2, 60)) @(negedge clk);
    end
    repeat (60) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
